// File: rtl/reg_bank.sv
// reg_bank: DEPTH x WIDTH register file with an in-place write operation,
// two registered write-first read ports, and registered zero/carry flags.
module reg_bank #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [2:0]       op,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b,
  output logic             zero,
  output logic             carry
);

  typedef enum logic [2:0] {
    OP_LOAD  = 3'b000,
    OP_CLEAR = 3'b001,
    OP_INC   = 3'b010,
    OP_DEC   = 3'b011,
    OP_SHL   = 3'b100,
    OP_SHR   = 3'b101,
    OP_ROL   = 3'b110,
    OP_ADD   = 3'b111
  } op_e;

  typedef logic [DEPTH-1:0][WIDTH-1:0] rf_t;

  rf_t              regs_q, regs_d;
  logic [WIDTH-1:0] rdata_a_q, rdata_a_d;
  logic [WIDTH-1:0] rdata_b_q, rdata_b_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;

  logic             wr_ok;
  logic [WIDTH-1:0] q_old;
  logic [WIDTH-1:0] res;
  logic             res_c;
  logic [WIDTH:0]   ext;

  // Address decode by comparison keeps out-of-range addresses reading as 0
  // without ever indexing past the array.
  function automatic logic [WIDTH-1:0] rd_sel(input rf_t rf, input logic [AW-1:0] a);
    logic [WIDTH-1:0] v;
    v = '0;
    for (int i = 0; i < DEPTH; i++)
      if (a == AW'(i)) v = rf[i];
    return v;
  endfunction

  assign wr_ok = we && ({1'b0, waddr} < (AW+1)'(DEPTH));

  // Old value of the write target
  always_comb q_old = rd_sel(regs_q, waddr);

  // Operation result and carry/borrow/shifted-out bit
  always_comb begin
    res   = '0;
    res_c = 1'b0;
    ext   = '0;
    case (op)
      OP_LOAD:  res = wdata;
      OP_CLEAR: res = '0;
      OP_INC: begin
        ext   = {1'b0, q_old} + (WIDTH+1)'(1);
        res   = ext[WIDTH-1:0];
        res_c = ext[WIDTH];
      end
      OP_DEC: begin
        // Borrow shows up as the extension bit wrapping to 1 when q_old == 0
        ext   = {1'b0, q_old} - (WIDTH+1)'(1);
        res   = ext[WIDTH-1:0];
        res_c = ext[WIDTH];
      end
      OP_SHL: begin
        res   = {q_old[WIDTH-2:0], 1'b0};
        res_c = q_old[WIDTH-1];
      end
      OP_SHR: begin
        res   = {1'b0, q_old[WIDTH-1:1]};
        res_c = q_old[0];
      end
      OP_ROL: begin
        res   = {q_old[WIDTH-2:0], q_old[WIDTH-1]};
        res_c = q_old[WIDTH-1];
      end
      OP_ADD: begin
        ext   = {1'b0, q_old} + {1'b0, wdata};
        res   = ext[WIDTH-1:0];
        res_c = ext[WIDTH];
      end
      default: ;
    endcase
  end

  // Next state: register file, flags, and read data taken from the
  // post-write file so a same-cycle write is seen by the reader
  always_comb begin
    regs_d = regs_q;
    if (wr_ok)
      for (int i = 0; i < DEPTH; i++)
        if (waddr == AW'(i)) regs_d[i] = res;
    zero_d    = wr_ok ? (res == '0) : zero_q;
    carry_d   = wr_ok ? res_c : carry_q;
    rdata_a_d = rd_sel(regs_d, raddr_a);
    rdata_b_d = rd_sel(regs_d, raddr_b);
  end

  // State registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q    <= '0;
      rdata_a_q <= '0;
      rdata_b_q <= '0;
      zero_q    <= 1'b0;
      carry_q   <= 1'b0;
    end else begin
      regs_q    <= regs_d;
      rdata_a_q <= rdata_a_d;
      rdata_b_q <= rdata_b_d;
      zero_q    <= zero_d;
      carry_q   <= carry_d;
    end
  end

  assign rdata_a = rdata_a_q;
  assign rdata_b = rdata_b_q;
  assign zero    = zero_q;
  assign carry   = carry_q;

endmodule

// File: tb/tb_reg_bank.sv
// Bench for reg_bank (DEPTH=6): directed plan steps plus random traffic,
// checked against an arithmetic reference model.
module tb_reg_bank;
  localparam int W   = 32;
  localparam int DEP = 6;
  localparam int AW  = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          we;
  logic [2:0]    op;
  logic [AW-1:0] waddr, raddr_a, raddr_b;
  logic [W-1:0]  wdata;
  logic [W-1:0]  rdata_a, rdata_b;
  logic          zero, carry;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] m [DEP];
  logic         mz, mc;

  reg_bank #(.WIDTH(W), .DEPTH(DEP), .AW(AW)) dut (
    .clk(clk), .rst(rst), .we(we), .op(op), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rdata_a), .rdata_b(rdata_b),
    .zero(zero), .carry(carry)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEP; i++) m[i] = '0;
    mz = 1'b0;
    mc = 1'b0;
  endtask

  // Reference op semantics in plain integer arithmetic
  task automatic model_op(input logic [2:0] o, input logic [W-1:0] q, input logic [W-1:0] d,
                          output logic [W-1:0] r, output logic c);
    longint lq, ld, s;
    lq = longint'(q);
    ld = longint'(d);
    r = '0; c = 1'b0;
    case (o)
      3'd0: r = d;
      3'd1: r = '0;
      3'd2: begin r = 32'((lq + 1) % 64'h1_0000_0000); c = (q == 32'hFFFF_FFFF); end
      3'd3: begin r = 32'((lq + 64'hFFFF_FFFF) % 64'h1_0000_0000); c = (q == 0); end
      3'd4: begin r = 32'((lq * 2) % 64'h1_0000_0000); c = (lq >= 64'h8000_0000); end
      3'd5: begin r = 32'(lq / 2); c = (lq % 2) == 1; end
      3'd6: begin r = 32'(((lq * 2) % 64'h1_0000_0000) + (lq / 64'h8000_0000));
                  c = (lq >= 64'h8000_0000); end
      default: begin s = lq + ld; r = 32'(s % 64'h1_0000_0000); c = (s >= 64'h1_0000_0000); end
    endcase
  endtask

  // One clock: drive, predict, clock, check all outputs
  task automatic cyc(input logic w, input logic [2:0] o, input logic [AW-1:0] wa,
                     input logic [W-1:0] wd, input logic [AW-1:0] a, input logic [AW-1:0] b,
                     input string tag);
    logic [W-1:0] r, ea, eb;
    logic c;
    we = w; op = o; waddr = wa; wdata = wd; raddr_a = a; raddr_b = b;
    if (w && int'(wa) < DEP) begin
      model_op(o, m[wa], wd, r, c);
      m[wa] = r;
      mz = (r == 0);
      mc = c;
    end
    ea = (int'(a) < DEP) ? m[a] : '0;
    eb = (int'(b) < DEP) ? m[b] : '0;
    @(posedge clk); #1;
    chk({tag, ".a"}, rdata_a, ea);
    chk({tag, ".b"}, rdata_b, eb);
    chk({tag, ".z"}, {31'b0, zero}, {31'b0, mz});
    chk({tag, ".c"}, {31'b0, carry}, {31'b0, mc});
  endtask

  initial begin
    logic [2:0] ro;
    logic [W-1:0] rd;
    rst = 1'b1; we = 0; op = 0; waddr = 0; wdata = 0; raddr_a = 0; raddr_b = 0;
    model_reset();
    #1;
    chk("rst.a", rdata_a, 0);
    chk("rst.b", rdata_b, 0);
    chk("rst.z", {31'b0, zero}, 0);
    chk("rst.c", {31'b0, carry}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // LOAD then read next cycle
    cyc(1, 3'd0, 2, 32'h00F4_30FE, 0, 0, "load");
    cyc(0, 3'd0, 0, 0, 2, 3, "read");
    chk("read.lit", rdata_a, 32'h00F4_30FE);

    // INC/DEC wrap, observed through bypass on port A
    cyc(1, 3'd0, 1, 32'hFFFF_FFFF, 1, 2, "ld1");
    cyc(1, 3'd2, 1, 0, 1, 2, "inc");
    chk("inc.lit", {rdata_a[30:0], zero, carry}, {31'b0, 2'b11});
    cyc(1, 3'd3, 1, 0, 1, 2, "dec");
    chk("dec.lit", {rdata_a[30:0], zero, carry}, {31'h7FFF_FFFF, 2'b01});

    // Shift / rotate / add
    cyc(1, 3'd0, 4, 32'h8000_0001, 4, 1, "ld4");
    cyc(1, 3'd4, 4, 0, 4, 1, "shl");
    chk("shl.lit", rdata_a, 32'h0000_0002);
    cyc(1, 3'd5, 4, 0, 4, 1, "shr");
    chk("shr.lit", {31'b0, carry}, 0);
    cyc(1, 3'd0, 4, 32'h8000_0000, 4, 1, "ld4b");
    cyc(1, 3'd6, 4, 0, 4, 1, "rol");
    chk("rol.lit", {rdata_a[30:0], carry}, 32'h0000_0003);
    cyc(1, 3'd7, 4, 32'hFFFF_FFFF, 4, 1, "add");
    chk("add.lit", {rdata_a[29:0], zero, carry}, 32'h0000_0003);

    // Write-first bypass
    cyc(1, 3'd0, 5, 32'hDEAD_BEEF, 0, 0, "ld5");
    cyc(1, 3'd0, 5, 32'h1234_0FE6, 5, 5, "byp");
    chk("byp.lit", rdata_a, 32'h1234_0FE6);

    // INC back-to-back counts by one per clock
    cyc(1, 3'd1, 3, 0, 3, 0, "clr3");
    for (int i = 0; i < 4; i++) cyc(1, 3'd2, 3, 0, 3, 0, "cnt");
    chk("cnt.lit", rdata_a, 32'd4);

    // Hold, then out-of-range write and read
    for (int i = 0; i < 10; i++) cyc(0, 3'($urandom_range(0, 7)), 3'(i % 6), $urandom, 3'(i % 6), 3'((i + 1) % 6), "hold");
    cyc(1, 3'd1, 7, 0, 3, 7, "oor");
    chk("oor.b", rdata_b, 0);
    cyc(1, 3'd2, 6, 0, 6, 5, "oor6");

    // Reset pulse between edges clears everything immediately
    cyc(1, 3'd0, 0, 32'h55AA_55AA, 0, 5, "pre");
    we = 0;
    rst = 1'b1;
    #2;
    model_reset();
    chk("mrst.a", rdata_a, 0);
    chk("mrst.b", rdata_b, 0);
    chk("mrst.z", {31'b0, zero}, 0);
    chk("mrst.c", {31'b0, carry}, 0);
    rst = 1'b0;
    cyc(0, 3'd0, 0, 0, 0, 5, "post");

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      ro = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: rd = 32'hFFFF_FFFF;
        1: rd = 32'($urandom_range(0, 3));
        default: rd = $urandom;
      endcase
      cyc(($urandom_range(0, 3) != 0), ro, 3'($urandom_range(0, 7)), rd,
          3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
